// File: rtl/bus_responder.sv
// bus_responder: fixed 4-beat burst responder with valid/ready handshake.
// A burst opens when valid is seen in IDLE; ready rises READY_LAT cycles
// later and stays high for exactly four beats; done pulses DONE_GAP cycles
// after the fourth beat.  Dropping valid before the fourth beat aborts the
// burst with a one-cycle err pulse.
// Optional feature: define BUS_RESPONDER_CSUM_EN to build the beat
// accumulator that drives csum; without it csum is tied to zero and all
// handshake timing is unchanged.
// Supported ranges: READY_LAT 1..4, DONE_GAP 1..4, READY_LAT+DONE_GAP <= 5.
module bus_responder #(
  parameter int DW        = 8,
  parameter int READY_LAT = 2,
  parameter int DONE_GAP  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [DW-1:0] data,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic [DW+1:0] csum
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    XFER = 3'd2,
    PROC = 3'd3,
    DONE = 3'd4
  } state_t;

  // Terminal values of the WAIT and PROC counters.  With a latency or gap of
  // one the corresponding state is skipped entirely, so the value is unused.
  localparam logic [1:0] WAIT_LAST = (READY_LAT >= 2) ? 2'(READY_LAT - 2) : 2'd0;
  localparam logic [1:0] GAP_LAST  = (DONE_GAP  >= 2) ? 2'(DONE_GAP  - 2) : 2'd0;

  state_t     state_q, state_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] gap_cnt_q, gap_cnt_d;

  // Strobes shared with the optional accumulator.
  logic burst_start;
  logic beat;
  logic burst_end;

  // Next-state, counter and registered-output decode for the handshake FSM.
  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    burst_start = 1'b0;
    beat        = 1'b0;
    burst_end   = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          burst_start = 1'b1;
          wait_cnt_d  = 2'd0;
          beat_cnt_d  = 2'd0;
          gap_cnt_d   = 2'd0;
          if (READY_LAT == 1) begin
            state_d = XFER;
            ready_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (!valid) begin
          err_d      = 1'b1;
          wait_cnt_d = 2'd0;
          state_d    = IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = 2'd0;
          ready_d    = 1'b1;
          state_d    = XFER;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end

      XFER: begin
        if (!(valid && ready_q)) begin
          err_d      = 1'b1;
          beat_cnt_d = 2'd0;
          state_d    = IDLE;
        end else begin
          beat = 1'b1;
          if (beat_cnt_q == 2'd3) begin
            beat_cnt_d = 2'd0;
            gap_cnt_d  = 2'd0;
            if (DONE_GAP == 1) begin
              done_d    = 1'b1;
              burst_end = 1'b1;
              state_d   = DONE;
            end else begin
              state_d = PROC;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 2'd1;
            ready_d    = 1'b1;
          end
        end
      end

      PROC: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 2'd0;
          done_d    = 1'b1;
          burst_end = 1'b1;
          state_d   = DONE;
        end else begin
          gap_cnt_d = gap_cnt_q + 2'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset wins over any same-edge request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      beat_cnt_q <= 2'd0;
      wait_cnt_q <= 2'd0;
      gap_cnt_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      beat_cnt_q <= beat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

`ifdef BUS_RESPONDER_CSUM_EN
  logic [DW+1:0] acc_q, acc_d;
  logic [DW+1:0] csum_q, csum_d;

  // Accumulate beats of the current burst; publish the total with done.
  always_comb begin
    acc_d  = acc_q;
    csum_d = csum_q;
    if (burst_start) begin
      acc_d = '0;
    end else if (beat) begin
      acc_d = acc_q + {2'b00, data};
    end
    if (burst_end) begin
      csum_d = acc_d;
    end
  end

  // Accumulator and published checksum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      csum_q <= '0;
    end else begin
      acc_q  <= acc_d;
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`else
  logic unused_csum_inputs;
  assign unused_csum_inputs = ^{data, burst_start, beat, burst_end};
  assign csum = '0;
`endif

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter DW, default 8, meaning the width of the data bus.
REQ-002 SHALL have parameter READY_LAT, default 2, range 1..4, meaning the number of cycles from first valid sample to ready.
REQ-003 SHALL have parameter DONE_GAP, default 2, range 1..4, meaning the number of cycles from the last accepted beat to the done pulse; READY_LAT+DONE_GAP <= 5.
REQ-004 SHALL have clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have valid, input, 1 bit: the initiator's burst request and beat qualifier.
REQ-007 SHALL have data, input, DW bits: beat payload, sampled when valid&ready.
REQ-008 SHALL have ready, output, 1 bit: the responder accepts a beat this cycle.
REQ-009 SHALL have done, output, 1 bit: a one-cycle pulse marking a completed 4-beat burst.
REQ-010 SHALL have err, output, 1 bit: a one-cycle pulse marking an aborted burst.
REQ-011 SHALL have busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have csum, output, DW+2 bits: the unsigned sum of the 4 beats of the last completed burst.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, XFER, PROC, DONE; ready, done and err SHALL be registered outputs.
REQ-014 In IDLE with valid=1 at cycle 0, SHALL go to WAIT, or to XFER directly when READY_LAT=1.
REQ-015 WAIT SHALL count so that ready is first high at cycle READY_LAT; valid dropping in WAIT SHALL cause err pulse, return to IDLE.
REQ-016 In XFER, ready SHALL be 1; each cycle with valid&ready SHALL be one beat, and the beat counter SHALL be 2 bits.
REQ-017 Exactly 4 beats SHALL be accepted; ready SHALL deassert the cycle after the 4th beat (ready high exactly 4 consecutive cycles).
REQ-018 valid=0 in any XFER cycle before the 4th beat SHALL abort: err=1 next cycle, ready=0, partial sum discarded, csum unchanged, state IDLE.
REQ-019 After the 4th beat, PROC SHALL wait so that done=1 exactly DONE_GAP cycles after the 4th beat cycle, for one cycle (DONE state); then IDLE.
REQ-020 Worst-case latency SHALL be: done at cycle READY_LAT+3+DONE_GAP <= 8 after the first valid.
REQ-021 valid during PROC/DONE SHALL be ignored; a new burst SHALL start only from IDLE (earliest cycle after done).
REQ-022 csum SHALL update in the same cycle done asserts and hold until the next completed burst; the accumulator SHALL be zeroed on burst start.
REQ-023 done and err SHALL never both be 1; busy SHALL equal (state != IDLE).

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, ready=0, done=0, err=0, busy=0, csum=0, counters=0.
REQ-025 rst asserted mid-burst SHALL drop ready the next cycle with no err or done pulse; the partial burst SHALL be lost.
REQ-026 rst SHALL dominate valid on the same edge.

Configuration
REQ-027 With BUS_RESPONDER_CSUM_EN defined, SHALL instantiate the accumulator and drive csum per REQ-022.
REQ-028 With BUS_RESPONDER_CSUM_EN undefined, SHALL omit the accumulator and tie csum to 0; all handshake timing SHALL be identical.

Verification
REQ-029 SHALL cover the nominal case: defaults, valid held 4 cycles after ready, data 1,2,3,4 -> ready high cycles 2..5, done at cycle 7, csum=10, err never.
REQ-030 SHALL cover the minimum-latency case: READY_LAT=1, DONE_GAP=1, data FF,FF,FF,FF (DW=8) -> ready cycles 1..4, done at cycle 5, csum=0x3FC.
REQ-031 SHALL cover abort in XFER: valid low on 3rd XFER cycle -> err pulse next cycle, no done, csum keeps previous value, busy=0 after.
REQ-032 SHALL cover reset mid-burst: rst=1 during 2nd beat -> next cycle ready=0, busy=0, csum=0, no err/done.
REQ-033 SHALL cover back-to-back bursts: valid held continuously -> second burst starts the cycle after done; two done pulses, csum updated twice.
REQ-034 SHALL cover the macro off: BUS_RESPONDER_CSUM_EN undefined, REQ-029 stimulus -> identical ready/done timing, csum=0 throughout.
